pdp8_cpu: RTL and testbench



---
 rtl/pdp8_pkg.sv | 40 ++++
 rtl/pdp8_opr.sv | 52 +++++
 rtl/pdp8_cpu.sv | 198 +++++++++++++++++++
 tb/tb_pdp8_cpu.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared definitions for the PDP-8 processor: state encodings, opcodes,
// reset vector and the link/accumulator rotate helpers.
package pdp8_pkg;

   typedef enum logic [3:0] {
      ST_F0 = 4'd0,
      ST_F1 = 4'd1,
      ST_F2 = 4'd2,
      ST_D0 = 4'd4,
      ST_D1 = 4'd5,
      ST_D2 = 4'd6,
      ST_E0 = 4'd8,
      ST_E1 = 4'd9,
      ST_E2 = 4'd10,
      ST_H  = 4'd15
   } state_t;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_TAD = 3'd1;
   localparam logic [2:0] OP_ISZ = 3'd2;
   localparam logic [2:0] OP_DCA = 3'd3;
   localparam logic [2:0] OP_JMS = 3'd4;
   localparam logic [2:0] OP_JMP = 3'd5;
   localparam logic [2:0] OP_IOT = 3'd6;
   localparam logic [2:0] OP_OPR = 3'd7;

   localparam logic [11:0] RESET_PC = 12'o0200;
   localparam logic [11:0] IOT_ION  = 12'o6001;
   localparam logic [11:0] IOT_IOF  = 12'o6002;

   // Rotates treat the link as bit 12 of a 13-bit {l,ac} register.
   function automatic logic [12:0] rotRight(input logic [12:0] v);
      return {v[0], v[12:1]};
   endfunction

   function automatic logic [12:0] rotLeft(input logic [12:0] v);
      return {v[11:0], v[12]};
   endfunction

endpackage

// File: rtl/pdp8_opr.sv
// Combinational evaluator for the operate (7xxx) microinstructions,
// groups 1, 2 and 3. Produces the new ac/link, the skip decision and halt.
module pdp8_opr
   import pdp8_pkg::*;
(
   input  logic [11:0] i_ir,
   input  logic [11:0] i_ac,
   input  logic        i_l,
   input  logic [11:0] i_switches,
   output logic [11:0] o_ac,
   output logic        o_l,
   output logic        o_skip,
   output logic        o_halt
);

   logic [12:0] w_lac;
   logic        w_cond;

   // Microoperations are applied sequentially on a working copy of {l,ac}.
   always_comb begin
      w_lac  = {i_l, i_ac};
      w_cond = 1'b0;
      o_skip = 1'b0;
      o_halt = 1'b0;
      if (!i_ir[8]) begin
         if (i_ir[7]) w_lac[11:0] = 12'd0;
         if (i_ir[6]) w_lac[12]   = 1'b0;
         if (i_ir[5]) w_lac[11:0] = ~w_lac[11:0];
         if (i_ir[4]) w_lac[12]   = ~w_lac[12];
         if (i_ir[0]) w_lac       = w_lac + 13'd1;
         if (i_ir[3] && !i_ir[2]) begin
            w_lac = rotRight(w_lac);
            if (i_ir[1]) w_lac = rotRight(w_lac);
         end else if (i_ir[2] && !i_ir[3]) begin
            w_lac = rotLeft(w_lac);
            if (i_ir[1]) w_lac = rotLeft(w_lac);
         end
      end else if (!i_ir[0]) begin
         // Skip sensing uses the accumulator before CLA/OSR modify it.
         w_cond = (i_ir[6] & i_ac[11]) | (i_ir[5] & (i_ac == 12'd0)) | (i_ir[4] & i_l);
         o_skip = w_cond ^ i_ir[3];
         if (i_ir[7]) w_lac[11:0] = 12'd0;
         if (i_ir[2]) w_lac[11:0] = w_lac[11:0] | i_switches;
         o_halt = i_ir[1];
      end else begin
         if (i_ir[7]) w_lac[11:0] = 12'd0;
      end
      o_ac = w_lac[11:0];
      o_l  = w_lac[12];
   end

endmodule

// File: rtl/pdp8_cpu.sv
// PDP-8 processor with internal 4096x12 core: fetch/defer/execute state
// machine, one state per clock, running until HLT.
module pdp8_cpu
   import pdp8_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] switches
);

   state_t      state, w_nextState;
   logic        run, jmp, l, interrupt_enable, interrupt;
   logic [11:0] pc, ir, ma, mb, ac;
   logic [11:0] mem [0:4095];

   state_t      w_unusedState;
   logic        w_runNext, w_jmpNext, w_lNext, w_ieNext;
   logic [11:0] w_pcNext, w_irNext, w_maNext, w_mbNext, w_acNext;
   logic        w_memWe;
   logic [11:0] w_memAddr, w_memData;

   logic [11:0] w_memRd, w_effAddr, w_mbInc, w_oprAc;
   logic [12:0] w_tadSum;
   logic        w_autoIndex, w_oprL, w_oprSkip, w_oprHalt, w_unused;

   assign w_memRd     = mem[ma];
   assign w_effAddr   = mb[7] ? {ma[11:7], mb[6:0]} : {5'b0, mb[6:0]};
   assign w_mbInc     = mb + 12'd1;
   assign w_tadSum    = {1'b0, ac} + {1'b0, mb};
   assign w_autoIndex = (ma[11:3] == 9'd1);
   assign w_unused    = ^ir[8:0];
   assign w_unusedState = ST_H;

   // The operate decoder sees mb because ir is only loaded on the same edge.
   pdp8_opr uOpr (
      .i_ir       (mb),
      .i_ac       (ac),
      .i_l        (l),
      .i_switches (switches),
      .o_ac       (w_oprAc),
      .o_l        (w_oprL),
      .o_skip     (w_oprSkip),
      .o_halt     (w_oprHalt)
   );

   always_ff @(posedge clk) begin
      if (reset_n) state <= ST_F0;
      else         state <= w_nextState;
   end

   always_comb begin
      w_nextState = ST_F0;
      case (state)
         ST_F0: w_nextState = (interrupt_enable & interrupt) ? ST_F0 : ST_F1;
         ST_F1: w_nextState = ST_F2;
         ST_F2: begin
            case (mb[11:9])
               OP_OPR:  w_nextState = w_oprHalt ? ST_H : ST_F0;
               OP_IOT:  w_nextState = ST_F0;
               OP_JMP:  w_nextState = mb[8] ? ST_D0 : ST_F0;
               default: w_nextState = mb[8] ? ST_D0 : ST_E0;
            endcase
         end
         ST_D0: w_nextState = ST_D1;
         ST_D1: w_nextState = ST_D2;
         ST_D2: w_nextState = jmp ? ST_F0 : ST_E0;
         ST_E0: w_nextState = ST_E1;
         ST_E1: w_nextState = (ir[11:9] == OP_ISZ) ? ST_E2 : ST_F0;
         ST_E2: w_nextState = ST_F0;
         ST_H:  w_nextState = ST_H;
         default: w_nextState = ST_F0;
      endcase
   end

   // Datapath next values; every register holds unless its state updates it.
   always_comb begin
      w_pcNext  = pc;
      w_irNext  = ir;
      w_maNext  = ma;
      w_mbNext  = mb;
      w_acNext  = ac;
      w_lNext   = l;
      w_jmpNext = jmp;
      w_runNext = run;
      w_ieNext  = interrupt_enable;
      w_memWe   = 1'b0;
      w_memAddr = ma;
      w_memData = mb;
      case (state)
         ST_F0: begin
            if (interrupt_enable & interrupt) begin
               w_memWe   = 1'b1;
               w_memAddr = 12'd0;
               w_memData = pc;
               w_pcNext  = 12'd1;
               w_ieNext  = 1'b0;
            end else begin
               w_maNext = pc;
            end
         end
         ST_F1: begin
            w_mbNext = w_memRd;
            w_pcNext = pc + 12'd1;
         end
         ST_F2: begin
            w_irNext  = mb;
            w_jmpNext = (mb[11:9] == OP_JMP);
            case (mb[11:9])
               OP_IOT: begin
                  if (mb == IOT_ION)      w_ieNext = 1'b1;
                  else if (mb == IOT_IOF) w_ieNext = 1'b0;
               end
               OP_OPR: begin
                  w_acNext = w_oprAc;
                  w_lNext  = w_oprL;
                  if (w_oprSkip) w_pcNext  = pc + 12'd1;
                  if (w_oprHalt) w_runNext = 1'b0;
               end
               default: begin
                  w_maNext = w_effAddr;
                  if (!mb[8] && mb[11:9] == OP_JMP) w_pcNext = w_effAddr;
               end
            endcase
         end
         ST_D0: w_mbNext = w_memRd;
         ST_D1: begin
            if (w_autoIndex) begin
               w_mbNext  = w_mbInc;
               w_memWe   = 1'b1;
               w_memData = w_mbInc;
            end
         end
         ST_D2: begin
            w_maNext = mb;
            if (jmp) w_pcNext = mb;
         end
         ST_E0: w_mbNext = w_memRd;
         ST_E1: begin
            case (ir[11:9])
               OP_AND: w_acNext = ac & mb;
               OP_TAD: begin
                  w_acNext = w_tadSum[11:0];
                  w_lNext  = l ^ w_tadSum[12];
               end
               OP_ISZ: w_mbNext = w_mbInc;
               OP_DCA: begin
                  w_memWe   = 1'b1;
                  w_memData = ac;
                  w_acNext  = 12'd0;
               end
               OP_JMS: begin
                  w_memWe   = 1'b1;
                  w_memData = pc;
                  w_pcNext  = ma + 12'd1;
               end
               default: ;
            endcase
         end
         ST_E2: begin
            w_memWe = 1'b1;
            if (mb == 12'd0) w_pcNext = pc + 12'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         pc               <= RESET_PC;
         ir               <= 12'd0;
         ma               <= 12'd0;
         mb               <= 12'd0;
         ac               <= 12'd0;
         l                <= 1'b0;
         jmp              <= 1'b0;
         run              <= 1'b1;
         interrupt_enable <= 1'b0;
         interrupt        <= 1'b0;
      end else begin
         pc               <= w_pcNext;
         ir               <= w_irNext;
         ma               <= w_maNext;
         mb               <= w_mbNext;
         ac               <= w_acNext;
         l                <= w_lNext;
         jmp              <= w_jmpNext;
         run              <= w_runNext;
         interrupt_enable <= w_ieNext;
         interrupt        <= 1'b0;
      end
   end

   // Core is not cleared by reset, and reset blocks any in-flight write.
   always_ff @(posedge clk) begin
      if (w_memWe && !reset_n) mem[w_memAddr] <= w_memData;
   end

endmodule

// File: tb/tb_pdp8_cpu.sv
// Directed programs for pdp8_cpu with hand-computed register and memory
// results checked after each program halts.
module tb_pdp8_cpu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] switches;

   int          checkCount;
   int          errorCount;
   int          cycles;
   logic [11:0] progQ [$];

   pdp8_cpu dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .switches (switches)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %o, expected %o", tag, observed, expected);
      end
   endtask

   // Reset, load the program at 0200, release reset and run to HLT.
   task automatic applyStimulus(input logic [11:0] prog [$]);
      @(negedge clk);
      reset_n = 1'b1;
      foreach (prog[i]) dut.mem[12'o0200 + i] = prog[i];
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      cycles = 0;
      while (dut.run && cycles < 500) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("haltReached", {11'b0, dut.run}, 12'd0);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset_n    = 1'b1;
      switches   = 12'd0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetPc",    dut.pc, 12'o0200);
      checkOutput("resetAc",    dut.ac, 12'o0000);
      checkOutput("resetL",     {11'b0, dut.l}, 12'd0);
      checkOutput("resetRun",   {11'b0, dut.run}, 12'd1);
      checkOutput("resetState", {8'b0, dut.state}, 12'd0);

      dut.mem[12'o0210] = 12'o0005;
      dut.mem[12'o0211] = 12'o7777;
      progQ = '{12'o7300, 12'o1210, 12'o3211, 12'o7402};
      applyStimulus(progQ);
      checkOutput("dcaMem",    dut.mem[12'o0211], 12'o0005);
      checkOutput("dcaAc",     dut.ac, 12'o0000);
      checkOutput("haltState", {8'b0, dut.state}, 12'd15);
      checkOutput("haltPc",    dut.pc, 12'o0204);
      checkOutput("addCycles", cycles[11:0], 12'd16);

      dut.mem[12'o0205] = 12'o7777;
      progQ = '{12'o7201, 12'o1205, 12'o7402};
      applyStimulus(progQ);
      checkOutput("tadCarryAc", dut.ac, 12'o0000);
      checkOutput("tadCarryL",  {11'b0, dut.l}, 12'd1);

      dut.mem[12'o0210] = 12'o7777;
      progQ = '{12'o7300, 12'o2210, 12'o7402, 12'o7040, 12'o7402};
      applyStimulus(progQ);
      checkOutput("iszMem", dut.mem[12'o0210], 12'o0000);
      checkOutput("iszAc",  dut.ac, 12'o7777);
      checkOutput("iszPc",  dut.pc, 12'o0205);

      dut.mem[12'o0300] = 12'o0000;
      dut.mem[12'o0301] = 12'o7402;
      progQ = '{12'o4300};
      applyStimulus(progQ);
      checkOutput("jmsLink", dut.mem[12'o0300], 12'o0201);
      checkOutput("jmsPc",   dut.pc, 12'o0302);
      checkOutput("jmsIr",   dut.ir, 12'o7402);

      dut.mem[12'o0010] = 12'o0377;
      dut.mem[12'o0400] = 12'o0042;
      progQ = '{12'o7300, 12'o1410, 12'o7402};
      applyStimulus(progQ);
      checkOutput("autoIndexPtr", dut.mem[12'o0010], 12'o0400);
      checkOutput("autoIndexAc",  dut.ac, 12'o0042);

      progQ = '{12'o7360, 12'o7402};
      applyStimulus(progQ);
      checkOutput("cmaCmlAc", dut.ac, 12'o7777);
      checkOutput("cmaCmlL",  {11'b0, dut.l}, 12'd1);

      progQ = '{12'o7300, 12'o7001, 12'o7012, 12'o7402};
      applyStimulus(progQ);
      checkOutput("rtrAc", dut.ac, 12'o4000);
      checkOutput("rtrL",  {11'b0, dut.l}, 12'd0);

      progQ = '{12'o7300, 12'o7001, 12'o7012, 12'o7006, 12'o7402};
      applyStimulus(progQ);
      checkOutput("rtlAc", dut.ac, 12'o0001);

      dut.mem[12'o0020] = 12'o0250;
      dut.mem[12'o0250] = 12'o7040;
      dut.mem[12'o0251] = 12'o7500;
      dut.mem[12'o0252] = 12'o7402;
      dut.mem[12'o0253] = 12'o7200;
      dut.mem[12'o0254] = 12'o7402;
      progQ = '{12'o5420};
      applyStimulus(progQ);
      checkOutput("jmpISmaPc",  dut.pc, 12'o0255);
      checkOutput("jmpISmaAc",  dut.ac, 12'o0000);
      checkOutput("jmpICycles", cycles[11:0], 12'd18);

      switches = 12'o1234;
      progQ = '{12'o7604, 12'o6001, 12'o7402};
      applyStimulus(progQ);
      checkOutput("osrAc", dut.ac, 12'o1234);
      checkOutput("ionIe", {11'b0, dut.interrupt_enable}, 12'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
